muldiv_sequencer: RTL and testbench

Multi-cycle RV32M multiply/divide unit beside the single-cycle ALU in the execute stage. It accepts one M-extension op per start pulse, iterates one bit per cycle (shift-add multiply, restoring divide), and raises stall so the core freezes PC/IF/ID while it runs. A one-cycle done pulse presents the result, which the writeback mux selects in place of alu_result.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 28 ++
 rtl/muldiv_sequencer.sv | 134 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  function automatic logic op_a_signed(input logic [2:0] f3);
    case (f3)
      MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    case (f3)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   m_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, m_i} : '0);
    // When the trial subtract succeeds the difference is below m, so a
    // modulo-2^XLEN subtract of the shifted remainder is exact.
    ge   = acc_i[2*XLEN-1:XLEN-1] >= {1'b0, m_i};
    diff = acc_i[2*XLEN-2:XLEN-1] - m_i;
    if (is_div) begin
      acc_o = ge ? {diff, acc_i[XLEN-2:0], 1'b1} : {acc_i[2*XLEN-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: one bit per cycle on magnitudes, sign fix-up at the end.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d, bz_q, bz_d;
  logic [2*XLEN-1:0] acc_q, acc_d, step_acc;
  logic [XLEN-1:0]   m_q, m_d, result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              sa_in, sb_in;
  logic [XLEN-1:0]   mag_a, mag_b, quo, rem, fix_res;
  logic [2*XLEN-1:0] prod;

  assign sa_in = op_a_signed(funct3) & op_a[XLEN-1];
  assign sb_in = op_b_signed(funct3) & op_b[XLEN-1];
  assign mag_a = sa_in ? -op_a : op_a;
  assign mag_b = sb_in ? -op_b : op_b;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (f3_q[2]),
    .acc_i  (acc_q),
    .m_i    (m_q),
    .acc_o  (step_acc)
  );

  // Divide-by-zero keeps the all-ones quotient regardless of operand signs.
  always_comb begin
    prod = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    quo  = ((sign_a_q ^ sign_b_q) && !bz_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (f3_q)
      MD_MUL:                       fix_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res = quo;
      default:                      fix_res = rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    bz_d     = bz_q;
    acc_d    = acc_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          state_d  = CALC;
          f3_d     = funct3;
          sign_a_d = sa_in;
          sign_b_d = sb_in;
          bz_d     = (op_b == '0);
          acc_d    = '0;
          acc_d[XLEN-1:0] = funct3[2] ? mag_a : mag_b;
          m_d      = funct3[2] ? mag_b : mag_a;
          cnt_d    = '0;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          result_d = fix_res;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      bz_q     <= 1'b0;
      acc_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      bz_q     <= bz_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign stall  = busy | (start & (state_q == IDLE) & !flush);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, scoreboard, corner sequences.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done;
  logic [31:0] result;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int dcnt   = 0;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
  } sb_t;
  sb_t scb[$];
  sb_t mon_e;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f3)
      MD_MUL:    begin p = sa * sb; return p[31:0]; end
      MD_MULH:   begin p = sa * sb; return p[63:32]; end
      MD_MULHSU: begin p = sa * ub; return p[63:32]; end
      MD_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      MD_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      MD_DIVU:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      MD_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default:   return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      dcnt++;
      if (scb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        mon_e = scb.pop_front();
        chk("result", result, mon_e.res);
        chk("done_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    sb_t e;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    e.res = exp; e.due = cyc + 34;
    scb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (scb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, scb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t         e;
    int unsigned t0;
    int          d0;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    tbl[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    tbl[1]  = '{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    tbl[2]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[4]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    tbl[5]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    tbl[6]  = '{MD_DIVU,   32'd100,        32'd7,         32'd14};
    tbl[7]  = '{MD_REMU,   32'd100,        32'd7,         32'd2};
    tbl[8]  = '{MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
    tbl[9]  = '{MD_REM,    32'd5,          32'd0,         32'd5};
    tbl[10] = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    tbl[11] = '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
    tbl[12] = '{MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF};
    tbl[13] = '{MD_DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF};
    tbl[14] = '{MD_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_stall", stall, 0);

    // start together with flush in IDLE is refused
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_busy", busy, 0);

    for (int i = 0; i < 15; i++) begin
      issue(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp);
      drain($sformatf("vec%0d_drain", i));
    end

    for (int i = 0; i < 8; i++) begin
      rf3 = 3'($urandom);
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      issue(rf3, ra, rb, ref_md(rf3, ra, rb));
      drain($sformatf("rand%0d_drain", i));
    end

    // synchronous reset in the middle of CALC
    @(posedge clk); #1;
    start = 1'b1; funct3 = MD_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    issue(MD_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    drain("post_rst_drain");

    // flush during CALC: no done, result keeps the previous value
    @(posedge clk); #1;
    start = 1'b1; funct3 = MD_DIV; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_stall", stall, 0);
    d0 = dcnt;
    repeat (40) @(negedge clk);
    chk("flush_no_done", dcnt, d0);
    chk("flush_result_held", result, 32'hFFFF_FFEB);

    // start held during busy is ignored: exactly one done
    @(posedge clk); #1;
    start = 1'b1; funct3 = MD_DIVU; op_a = 32'd100; op_b = 32'd7;
    e.res = 32'd14; e.due = cyc + 34;
    scb.push_back(e);
    d0 = dcnt;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      funct3 = MD_MUL; op_a = $urandom; op_b = $urandom;
    end
    start = 1'b0;
    drain("busy_start_drain");
    repeat (40) @(negedge clk);
    chk("busy_start_one_done", dcnt, d0 + 1);

    // back-to-back: start held across the done cycle
    @(posedge clk); #1;
    start = 1'b1; funct3 = MD_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    t0 = cyc;
    e.res = 32'hFFFF_FFEB; e.due = t0 + 34;
    scb.push_back(e);
    @(negedge clk);
    chk("b2b_stall_c0", stall, 1);
    for (int c = 1; c <= 68; c++) begin
      @(posedge clk); #1;
      if (c == 34) begin
        funct3 = MD_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        e.res = 32'hFFFF_FFFE; e.due = t0 + 68;
        scb.push_back(e);
      end
      if (c == 35) begin
        start = 1'b0; op_a = $urandom; op_b = $urandom;
      end
      @(negedge clk);
      chk($sformatf("b2b_stall_c%0d", c), stall, (c < 68) ? 32'd1 : 32'd0);
      if (c == 1 || c == 33) chk($sformatf("b2b_busy_c%0d", c), busy, 1);
      if (c == 34) chk("b2b_busy_c34", busy, 0);
    end
    drain("b2b_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
